// File: rtl/hpdcache_mfifo_pkg.sv
// Shared width helpers for the register-based multi-channel FIFO.
package hpdcache_mfifo_pkg;

    // Width of a channel index; at least one bit even for a single channel
    function automatic int unsigned mfifo_chw(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Width of an occupancy counter able to hold 0..depth
    function automatic int unsigned mfifo_cw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a pointer addressing 0..depth-1
    function automatic int unsigned mfifo_pw(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/hpdcache_mfifo_ctrl.sv
// Per-channel control of the multi-channel FIFO: read/write pointers,
// occupancy counter and empty/full flags. One instance per channel.
module hpdcache_mfifo_ctrl
    import hpdcache_mfifo_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)(
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        wexec_i,
    input  logic                        rexec_i,
    input  logic                        flush_i,
    output logic [mfifo_pw(DEPTH)-1:0]  wptr_o,
    output logic [mfifo_pw(DEPTH)-1:0]  rptr_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic [mfifo_cw(DEPTH)-1:0]  count_o
);

    localparam int unsigned PW = mfifo_pw(DEPTH);
    localparam int unsigned CW = mfifo_cw(DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_wptrNext;
    logic [PW-1:0] w_rptrNext;

    // Next pointer values wrap explicitly so that non-power-of-two depths work
    always_comb begin
        w_wptrNext = (r_wptr == LAST_PTR) ? '0 : r_wptr + PW'(1);
        w_rptrNext = (r_rptr == LAST_PTR) ? '0 : r_rptr + PW'(1);
    end

    // Pointer and occupancy state; flush wins over any access in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (wexec_i) r_wptr <= w_wptrNext;
            if (rexec_i) r_rptr <= w_rptrNext;
            unique case ({wexec_i, rexec_i})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign wptr_o  = r_wptr;
    assign rptr_o  = r_rptr;
    assign count_o = r_count;
    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == DEPTH_CNT);

    // The counter must always agree with the pointer distance
    a_countMatchesPtrs : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (int'(r_count) == ((int'(r_wptr) - int'(r_rptr) + int'(DEPTH)) % int'(DEPTH))) ||
        ((r_wptr == r_rptr) && (r_count == DEPTH_CNT)));

endmodule

// File: rtl/hpdcache_mfifo_reg.sv
// Register-based multi-channel FIFO: NCH queues of DEPTH entries sharing one
// write port and one read port, steered by channel indexes.
// Optional same-cycle write-to-read bypass on an empty channel is enabled by
// defining HPDCACHE_MFIFO_BYPASS_EN.
module hpdcache_mfifo_reg
    import hpdcache_mfifo_pkg::*;
#(
    parameter int unsigned NCH          = 2,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned AFULL_THRESH = DEPTH - 1,
    parameter type         fifo_data_t  = logic
)(
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              w_i,
    input  logic [mfifo_chw(NCH)-1:0]         wch_i,
    input  fifo_data_t                        wdata_i,
    output logic                              wok_o,
    input  logic                              r_i,
    input  logic [mfifo_chw(NCH)-1:0]         rch_i,
    output logic                              rok_o,
    output fifo_data_t                        rdata_o,
    input  logic [NCH-1:0]                    flush_i,
    output logic [NCH-1:0]                    nempty_o,
    output logic [NCH-1:0]                    afull_o,
    output logic [NCH*mfifo_cw(DEPTH)-1:0]    count_o
);

    localparam int unsigned CHW = mfifo_chw(NCH);
    localparam int unsigned CW  = mfifo_cw(DEPTH);
    localparam int unsigned PW  = mfifo_pw(DEPTH);

    fifo_data_t    r_mem [NCH][DEPTH];
    logic [PW-1:0] w_wptr [NCH];
    logic [PW-1:0] w_rptr [NCH];
    logic [CW-1:0] w_count [NCH];
    logic [NCH-1:0] w_empty;
    logic [NCH-1:0] w_full;
    logic [NCH-1:0] w_wexec;
    logic [NCH-1:0] w_rexec;
    logic w_wchValid;
    logic w_rchValid;
    logic w_bypass;

    assign w_wchValid = (32'(wch_i) < NCH);
    assign w_rchValid = (32'(rch_i) < NCH);

`ifdef HPDCACHE_MFIFO_BYPASS_EN
    assign w_bypass = w_i & w_wchValid & w_rchValid & (wch_i == rch_i) &
                      w_empty[rch_i] & ~flush_i[rch_i];
`else
    assign w_bypass = 1'b0;
`endif

    // Handshake outputs and read data mux; a pending flush blocks both ports
    always_comb begin
        wok_o   = 1'b0;
        rok_o   = 1'b0;
        rdata_o = '0;
        if (w_wchValid) begin
            wok_o = ~w_full[wch_i] & ~flush_i[wch_i];
        end
        if (w_rchValid) begin
            rok_o   = ~w_empty[rch_i] & ~flush_i[rch_i];
            rdata_o = r_mem[rch_i][w_rptr[rch_i]];
        end
        if (w_bypass) begin
            rok_o   = 1'b1;
            rdata_o = wdata_i;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : gen_ch
        // A bypassed entry that is popped the same cycle never touches the queue
        assign w_wexec[c] = w_i & wok_o & (wch_i == CHW'(c)) & ~(w_bypass & r_i);
        assign w_rexec[c] = r_i & rok_o & (rch_i == CHW'(c)) & ~w_bypass;

        hpdcache_mfifo_ctrl #(
            .DEPTH   (DEPTH)
        ) i_ctrl (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .wexec_i (w_wexec[c]),
            .rexec_i (w_rexec[c]),
            .flush_i (flush_i[c]),
            .wptr_o  (w_wptr[c]),
            .rptr_o  (w_rptr[c]),
            .empty_o (w_empty[c]),
            .full_o  (w_full[c]),
            .count_o (w_count[c])
        );

        assign nempty_o[c]          = ~w_empty[c];
        assign afull_o[c]           = (w_count[c] >= CW'(AFULL_THRESH));
        assign count_o[c*CW +: CW]  = w_count[c];
    end

    // Storage write: accepted data lands at the target channel's write pointer
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NCH; c++) begin
            if (w_wexec[c]) r_mem[c][w_wptr[c]] <= wdata_i;
        end
    end

endmodule
